// File: rtl/issue_pair_sched_pkg.sv
// issue_pkg: shared opcode decode and types for the dual-issue pair scheduler
package issue_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic {PAIR, REPLAY} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] r;
    } dest_t;

    function automatic logic is_way0(input logic [31:0] inst);
        logic [5:0] op;
        op = inst[31:26];
        return (op == OP_RTYPE && inst[5:0] == FN_JR) ||
               (op inside {OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_LW, OP_SW});
    endfunction

    // I-type ALU ops occupy opcodes 001xxx
    function automatic dest_t dest_reg(input logic [31:0] inst);
        logic [5:0] op;
        op = inst[31:26];
        return op == OP_RTYPE ? dest_t'{inst[5:0] != FN_JR, inst[15:11]} :
               (op == OP_LW || op[5:3] == 3'b001) ? dest_t'{1'b1, inst[20:16]} :
               op == OP_JAL ? dest_t'{1'b1, 5'd31} : dest_t'{1'b0, 5'd0};
    endfunction

    function automatic logic reads_rt(input logic [31:0] inst);
        return inst[31:26] inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
    endfunction
endpackage

// File: rtl/issue_pair_sched_if.sv
// issue_pair_sched_if: fetch-side pair input and issue-side slot outputs
interface issue_pair_sched_if #(parameter int CNT_W = 16);
    logic             fetch_valid;
    logic [31:0]      inst_0, pc_0, inst_1, pc_1;
    logic             pipe_stall, flush;
    logic [31:0]      iss_inst_0, iss_pc_0, iss_inst_1, iss_pc_1;
    logic             iss_valid_0, iss_valid_1;
    logic             fetch_stall;
    logic [CNT_W-1:0] split_cnt;

    modport master (
        output fetch_valid, inst_0, pc_0, inst_1, pc_1, pipe_stall, flush,
        input  iss_inst_0, iss_pc_0, iss_valid_0, iss_inst_1, iss_pc_1, iss_valid_1,
               fetch_stall, split_cnt
    );
    modport slave (
        input  fetch_valid, inst_0, pc_0, inst_1, pc_1, pipe_stall, flush,
        output iss_inst_0, iss_pc_0, iss_valid_0, iss_inst_1, iss_pc_1, iss_valid_1,
               fetch_stall, split_cnt
    );
endinterface

// File: rtl/issue_pair_sched_hazard.sv
// pair_hazard_detect: flags pairs that cannot dual-issue; reason = {raw, structural}
module pair_hazard_detect import issue_pkg::*; (
    input  logic [31:0] inst_0,
    input  logic [31:0] inst_1,
    output logic        split,
    output logic [1:0]  reason
);
    dest_t d;
    assign d = dest_reg(inst_0);
    assign reason[0] = is_way0(inst_0) & is_way0(inst_1);
    assign reason[1] = d.valid & (d.r != 5'd0) &
                       ((d.r == inst_1[25:21]) | (reads_rt(inst_1) & (d.r == inst_1[20:16])));
    assign split = |reason;
endmodule

// File: rtl/issue_pair_sched.sv
// issue_pair_sched: dual-issue pair scheduler that splits hazardous pairs and replays the younger
module issue_pair_sched import issue_pkg::*; #(
    parameter int          CNT_W = 16,
    parameter logic [31:0] NOP   = NOP_INST
) (
    input logic               clk,
    input logic               rst_n,
    issue_pair_sched_if.slave bus
);
    state_t           state;
    logic [31:0]      buf_inst, buf_pc;
    logic [CNT_W-1:0] cnt;
    logic             pair_split, split, take_pair;
    logic [1:0]       reason;

    pair_hazard_detect hazard (
        .inst_0(bus.inst_0),
        .inst_1(bus.inst_1),
        .split (pair_split),
        .reason(reason)
    );

    assign split = bus.fetch_valid & (pair_split | (|reason));
    assign take_pair = (state == PAIR) & bus.fetch_valid & ~split;
    assign bus.fetch_stall = (state == REPLAY) | bus.pipe_stall;
    assign bus.split_cnt = cnt;

    // flush shares the reset clearing path but leaves the split counter alone
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            state           <= PAIR;
            buf_inst        <= NOP;
            buf_pc          <= '0;
            bus.iss_inst_0  <= NOP;
            bus.iss_pc_0    <= '0;
            bus.iss_valid_0 <= 1'b0;
            bus.iss_inst_1  <= NOP;
            bus.iss_pc_1    <= '0;
            bus.iss_valid_1 <= 1'b0;
            if (!rst_n) cnt <= '0;
        end else if (!bus.pipe_stall) begin
            state           <= (state == PAIR && split) ? REPLAY : PAIR;
            bus.iss_inst_0  <= state == REPLAY ? buf_inst : bus.fetch_valid ? bus.inst_0 : NOP;
            bus.iss_pc_0    <= state == REPLAY ? buf_pc : bus.fetch_valid ? bus.pc_0 : '0;
            bus.iss_valid_0 <= (state == REPLAY) | bus.fetch_valid;
            bus.iss_inst_1  <= take_pair ? bus.inst_1 : NOP;
            bus.iss_pc_1    <= take_pair ? bus.pc_1 : '0;
            bus.iss_valid_1 <= take_pair;
            if (state == PAIR && split) begin
                buf_inst <= bus.inst_1;
                buf_pc   <= bus.pc_1;
                cnt      <= &cnt ? cnt : cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_issue_pair_sched.sv
// tb_issue_pair_sched: directed plus random stimulus against a queue-based reference model
module tb_issue_pair_sched;
    localparam int CW = 3;
    localparam logic [31:0] LW9 = 32'h8D09_0000, SW10 = 32'hAD0A_0004;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    issue_pair_sched_if #(.CNT_W(CW)) bus ();
    issue_pair_sched #(.CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic [31:0]   i0, p0, i1, p1;
        logic          v0, v1, fs;
        logic [CW-1:0] cnt;
    } obs_t;
    typedef struct {logic [31:0] inst, pc;} op_t;

    obs_t exp_q[$];
    op_t  replay_q[$];
    obs_t m, e;
    int   tests = 0, fails = 0;

    function automatic bit way0(logic [31:0] x);
        int op = int'(x[31:26]);
        return op == 0 ? x[5:0] == 6'd8 : (op inside {2, 3, 4, 5, 35, 43});
    endfunction

    function automatic int dest(logic [31:0] x);
        int op = int'(x[31:26]);
        if (op == 0) return x[5:0] == 6'd8 ? -1 : int'(x[15:11]);
        if (op == 35 || (op >= 8 && op <= 15)) return int'(x[20:16]);
        if (op == 3) return 31;
        return -1;
    endfunction

    function automatic bit must_split(logic [31:0] a, logic [31:0] b);
        int d = dest(a);
        int op = int'(b[31:26]);
        bit hit = d > 0 && (d == int'(b[25:21]) || (op inside {0, 4, 5, 43} && d == int'(b[20:16])));
        return (way0(a) && way0(b)) || hit;
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [5:0] op, fn;
        int k = $urandom_range(0, 10);
        case (k)
            0, 1: op = 6'd0;
            2: op = 6'd2;
            3: op = 6'd3;
            4: op = 6'd4;
            5: op = 6'd5;
            6: op = 6'd35;
            7: op = 6'd43;
            8: op = 6'd8;
            9: op = 6'd15;
            default: op = 6'd32;
        endcase
        fn = k == 1 ? 6'h08 : 6'h20;
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'd0, fn};
    endfunction

    task automatic clr_slots();
        m.i0 = '0; m.p0 = '0; m.v0 = 1'b0;
        m.i1 = '0; m.p1 = '0; m.v1 = 1'b0;
    endtask

    task automatic cycle(bit rs, bit fv, logic [31:0] i0, logic [31:0] p0,
                         logic [31:0] i1, logic [31:0] p1, bit st, bit fl);
        op_t r;
        rst_n = !rs; bus.fetch_valid = fv; bus.pipe_stall = st; bus.flush = fl;
        bus.inst_0 = i0; bus.pc_0 = p0; bus.inst_1 = i1; bus.pc_1 = p1;
        if (rs || fl) begin
            replay_q.delete();
            clr_slots();
            if (rs) m.cnt = '0;
        end else if (!st) begin
            if (replay_q.size() != 0) begin
                r = replay_q.pop_front();
                clr_slots();
                m.i0 = r.inst; m.p0 = r.pc; m.v0 = 1'b1;
            end else if (!fv) begin
                clr_slots();
            end else if (must_split(i0, i1)) begin
                clr_slots();
                m.i0 = i0; m.p0 = p0; m.v0 = 1'b1;
                replay_q.push_back('{i1, p1});
                if (int'(m.cnt) < (1 << CW) - 1) m.cnt = m.cnt + 1'b1;
            end else begin
                m.i0 = i0; m.p0 = p0; m.v0 = 1'b1;
                m.i1 = i1; m.p1 = p1; m.v1 = 1'b1;
            end
        end
        m.fs = (replay_q.size() != 0) || st;
        exp_q.push_back(m);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("valid_0", 32'(bus.iss_valid_0), 32'(e.v0));
            chk("valid_1", 32'(bus.iss_valid_1), 32'(e.v1));
            chk("inst_0", bus.iss_inst_0, e.i0);
            chk("inst_1", bus.iss_inst_1, e.i1);
            if (e.v0) chk("pc_0", bus.iss_pc_0, e.p0);
            if (e.v1) chk("pc_1", bus.iss_pc_1, e.p1);
            chk("fetch_stall", 32'(bus.fetch_stall), 32'(e.fs));
            chk("split_cnt", 32'(bus.split_cnt), 32'(e.cnt));
        end
    end

    initial begin
        m = '{default: '0};
        cycle(1, 1, LW9, 32'h100, SW10, 32'h104, 0, 0);
        cycle(1, 1, LW9, 32'h100, SW10, 32'h104, 0, 0);
        cycle(0, 1, LW9, 32'h100, 32'h01AE_6020, 32'h104, 0, 0);
        cycle(0, 1, LW9, 32'h100, SW10, 32'h104, 0, 0);
        cycle(0, 1, 32'h1234_5678, 32'h200, 32'h1234_5678, 32'h204, 0, 0);
        cycle(0, 0, '0, '0, '0, '0, 0, 0);
        cycle(0, 1, LW9, 32'h100, 32'h012B_5020, 32'h104, 0, 0);
        cycle(0, 0, '0, '0, '0, '0, 0, 0);
        cycle(0, 1, 32'h0022_0020, 32'h300, 32'h0000_1820, 32'h304, 0, 0);
        cycle(0, 1, LW9, 32'h100, SW10, 32'h104, 0, 0);
        cycle(0, 1, LW9, 32'h100, SW10, 32'h104, 0, 1);
        cycle(0, 0, '0, '0, '0, '0, 0, 0);
        cycle(0, 1, LW9, 32'h100, SW10, 32'h104, 0, 0);
        repeat (3) cycle(0, 1, LW9, 32'h400, SW10, 32'h404, 1, 0);
        cycle(0, 0, '0, '0, '0, '0, 0, 0);
        cycle(0, 0, '0, '0, '0, '0, 0, 0);
        repeat (10) cycle(0, 1, LW9, 32'h500, SW10, 32'h504, 0, 0);
        cycle(0, 1, LW9, 32'h100, SW10, 32'h104, 1, 1);
        for (int n = 0; n < 3000; n++)
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                  rnd_inst(), $urandom, rnd_inst(), $urandom,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0);
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
